move_commit_ctrl: RTL and testbench

- Consumer end of the move-mask interface; drives `selected_figure`/`position` into the move-generation logic and consumes the returned `possible_moves` mask.
- Owns the authoritative 8x8 board register and the side-to-move flag.
- Turns player click pulses into select / deselect / reselect / commit actions, legality-gated by the mask.
- Sits between the cursor/click front-end and the move-generation logic; its `board` output feeds both the move logic and the renderer.

---
 rtl/move_commit_ctrl.sv | 163 ++++++++++++++++
 tb/tb_move_commit_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/move_commit_ctrl.sv
// Board owner and click-to-move controller: select, await move mask, then commit or reject.
// Mask sampled MASK_WAIT cycles after selection; commit takes one cycle; move_done/illegal are registered pulses.
module move_commit_ctrl #(
    parameter int MASK_WAIT = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  click_valid,
    input  logic [5:0]            click_square,
    input  logic [63:0]           possible_moves,
    output logic [3:0]            selected_figure,
    output logic [5:0]            position,
    output logic [7:0][7:0][3:0]  board,
    output logic                  turn,
    output logic                  sel_active,
    output logic                  move_done,
    output logic                  illegal,
    output logic [3:0]            captured,
    output logic                  game_over
);

    localparam int CW = (MASK_WAIT < 2) ? 1 : $clog2(MASK_WAIT + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(MASK_WAIT);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {IDLE, WAIT, SELECTED, COMMIT} state_t;

    function automatic logic is_own(input logic [3:0] code, input logic t);
        if (t)
            return (code >= 4'd7) && (code <= 4'd12);
        return (code >= 4'd1) && (code <= 4'd6);
    endfunction

    function automatic logic [7:0][7:0][3:0] start_board();
        logic [7:0][7:0][3:0] b;
        b = '0;
        for (int c = 0; c < 8; c++) begin
            b[6][c] = 4'd1;
            b[1][c] = 4'd7;
        end
        b[7] = {4'd4, 4'd2, 4'd3, 4'd6, 4'd5, 4'd3, 4'd2, 4'd4};
        b[0] = {4'd10, 4'd8, 4'd9, 4'd12, 4'd11, 4'd9, 4'd8, 4'd10};
        return b;
    endfunction

    state_t        state, nxt;
    logic [CW-1:0] cnt;
    logic [63:0]   mask_q;
    logic [5:0]    dst_q;

    logic [3:0] click_piece;
    logic [5:0] mask_idx;
    logic       click_en, click_own, click_hit, click_same;
    logic       do_select, do_deselect, do_illegal, do_sample, do_dst;
    logic [3:0] moved_piece, dst_old;

    assign click_piece = board[click_square[5:3]][click_square[2:0]];
    assign mask_idx    = 6'd63 - click_square;
    assign click_en    = click_valid && !game_over;
    assign click_own   = is_own(click_piece, turn);
    assign click_hit   = mask_q[mask_idx];
    assign click_same  = (click_square == position);
    assign dst_old     = board[dst_q[5:3]][dst_q[2:0]];

    // Pawns reaching the far rank always promote to a queen.
    always_comb begin
        moved_piece = selected_figure;
        if (selected_figure == 4'd1 && dst_q[5:3] == 3'd0)
            moved_piece = 4'd5;
        else if (selected_figure == 4'd7 && dst_q[5:3] == 3'd7)
            moved_piece = 4'd11;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:     if (click_en && click_own) nxt = WAIT;
            WAIT:     if (cnt == CNT_ONE) nxt = (possible_moves == '0) ? IDLE : SELECTED;
            SELECTED: if (click_en) begin
                          if (click_same)     nxt = IDLE;
                          else if (click_own) nxt = WAIT;
                          else if (click_hit) nxt = COMMIT;
                      end
            COMMIT:   nxt = IDLE;
            default:  nxt = IDLE;
        endcase
    end

    always_comb begin
        do_select   = 1'b0;
        do_deselect = 1'b0;
        do_illegal  = 1'b0;
        do_sample   = 1'b0;
        do_dst      = 1'b0;
        sel_active  = (state == WAIT) || (state == SELECTED);
        case (state)
            IDLE: if (click_en) begin
                      do_select  = click_own;
                      do_illegal = !click_own;
                  end
            WAIT: if (cnt == CNT_ONE) begin
                      do_sample   = 1'b1;
                      do_illegal  = (possible_moves == '0);
                      do_deselect = (possible_moves == '0);
                  end
            SELECTED: if (click_en) begin
                          if (click_same)     do_deselect = 1'b1;
                          else if (click_own) do_select   = 1'b1;
                          else if (click_hit) do_dst      = 1'b1;
                          else                do_illegal  = 1'b1;
                      end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            board           <= start_board();
            selected_figure <= '0;
            position        <= '0;
            turn            <= 1'b0;
            move_done       <= 1'b0;
            illegal         <= 1'b0;
            captured        <= '0;
            game_over       <= 1'b0;
            cnt             <= '0;
            mask_q          <= '0;
            dst_q           <= '0;
        end else begin
            illegal   <= do_illegal;
            move_done <= (state == COMMIT);
            if (do_select) begin
                position        <= click_square;
                selected_figure <= click_piece;
                cnt             <= CNT_INIT;
            end else if (state == WAIT) begin
                cnt <= cnt - CNT_ONE;
            end
            if (do_sample)
                mask_q <= possible_moves;
            if (do_deselect)
                selected_figure <= '0;
            if (do_dst)
                dst_q <= click_square;
            if (state == COMMIT) begin
                board[dst_q[5:3]][dst_q[2:0]]       <= moved_piece;
                board[position[5:3]][position[2:0]] <= '0;
                captured        <= dst_old;
                game_over       <= game_over || (dst_old == 4'd6) || (dst_old == 4'd12);
                turn            <= !turn;
                selected_figure <= '0;
            end
        end
    end

endmodule

// File: tb/tb_move_commit_ctrl.sv
// Scoreboarded bench for move_commit_ctrl: expected pulses queued at stimulus, matched on output.
module tb_move_commit_ctrl;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 click_valid = 1'b0;
    logic [5:0]           click_square = '0;
    logic [63:0]          possible_moves = '0;
    logic [3:0]           selected_figure;
    logic [5:0]           position;
    logic [7:0][7:0][3:0] board;
    logic                 turn, sel_active, move_done, illegal, game_over;
    logic [3:0]           captured;

    move_commit_ctrl #(.MASK_WAIT(2)) dut (
        .clk(clk), .rst(rst), .click_valid(click_valid), .click_square(click_square),
        .possible_moves(possible_moves), .selected_figure(selected_figure), .position(position),
        .board(board), .turn(turn), .sel_active(sel_active), .move_done(move_done),
        .illegal(illegal), .captured(captured), .game_over(game_over)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] kind;   // 1 = illegal pulse, 2 = move_done pulse
        logic [3:0] cap;
    } ev_t;

    ev_t                  sb[$];
    int                   checks = 0;
    int                   failures = 0;
    logic [7:0][7:0][3:0] exp_board;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic init_board();
        int back_w[8] = '{4, 2, 3, 5, 6, 3, 2, 4};
        int back_b[8] = '{10, 8, 9, 11, 12, 9, 8, 10};
        exp_board = '0;
        for (int c = 0; c < 8; c++) begin
            exp_board[7][c] = 4'(back_w[c]);
            exp_board[6][c] = 4'd1;
            exp_board[1][c] = 4'd7;
            exp_board[0][c] = 4'(back_b[c]);
        end
    endtask

    function automatic logic [63:0] mbit(input int sq);
        return 64'd1 << (63 - sq);
    endfunction

    task automatic push_ev(input logic [1:0] kind, input logic [3:0] cap);
        ev_t e;
        e.kind = kind;
        e.cap  = cap;
        sb.push_back(e);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic click(input int sq);
        @(posedge clk);
        #1;
        click_valid  = 1'b1;
        click_square = 6'(sq);
        @(posedge clk);
        #1;
        click_valid = 1'b0;
    endtask

    // Full move with a static mask allowing only dst; updates the reference board.
    task automatic do_move(input int src, input int dst);
        logic [3:0] piece, cap;
        piece = exp_board[src / 8][src % 8];
        cap   = exp_board[dst / 8][dst % 8];
        possible_moves = mbit(dst);
        click(src);
        wait_cycles(2);
        push_ev(2'd2, cap);
        click(dst);
        wait_cycles(2);
        if (piece == 4'd1 && dst / 8 == 0) piece = 4'd5;
        if (piece == 4'd7 && dst / 8 == 7) piece = 4'd11;
        exp_board[dst / 8][dst % 8] = piece;
        exp_board[src / 8][src % 8] = 4'd0;
        check("move_drain", 256'(sb.size()), 256'd0);
        check("move_board", board, exp_board);
    endtask

    always @(negedge clk) begin
        if (!rst && (illegal || move_done)) begin
            if (sb.size() == 0) begin
                check("ev_unexpected", 256'({move_done, illegal}), 256'd0);
            end else begin
                ev_t e;
                e = sb.pop_front();
                check("ev_kind", 256'({move_done, illegal}), 256'(e.kind));
                if (e.kind == 2'd2)
                    check("ev_captured", 256'(captured), 256'(e.cap));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        init_board();
        #23;
        check("rst_board", board, exp_board);
        check("rst_sel_fig", 256'(selected_figure), 256'd0);
        @(negedge clk);
        rst = 1'b0;
        wait_cycles(1);
        check("init_turn", 256'(turn), 256'd0);
        check("init_flags", 256'({sel_active, move_done, illegal, game_over}), 256'd0);
        check("init_captured", 256'(captured), 256'd0);

        // Reset in the middle of WAIT
        possible_moves = mbit(44);
        click(52);
        check("wait_sel_fig", 256'(selected_figure), 256'd1);
        #2 rst = 1'b1;
        #1;
        check("midrst_sel", 256'({sel_active, selected_figure, turn, game_over}), 256'd0);
        check("midrst_board", board, exp_board);
        @(negedge clk);
        rst = 1'b0;

        // Opponent piece, then empty square
        push_ev(2'd1, 4'd0);
        click(12);
        push_ev(2'd1, 4'd0);
        click(40);
        wait_cycles(2);
        check("wrong_drain", 256'(sb.size()), 256'd0);
        check("wrong_sel_active", 256'(sel_active), 256'd0);
        check("wrong_board", board, exp_board);

        // Zero mask with a click dropped during WAIT
        possible_moves = '0;
        push_ev(2'd1, 4'd0);
        click(63);
        check("zm_sel_fig", 256'(selected_figure), 256'd4);
        check("zm_position", 256'(position), 256'd63);
        click(40);
        wait_cycles(2);
        check("zm_drain", 256'(sb.size()), 256'd0);
        check("zm_idle", 256'({sel_active, selected_figure}), 256'd0);

        // Reselect, dropped click while re-waiting, deselect
        possible_moves = mbit(44);
        click(52);
        wait_cycles(2);
        check("rs_selected", 256'(sel_active), 256'd1);
        click(51);
        check("rs_position", 256'(position), 256'd51);
        check("rs_sel_fig", 256'(selected_figure), 256'd1);
        click(51);
        check("rs_rewait_drop", 256'({sel_active, selected_figure}), 256'h11);
        wait_cycles(1);
        click(51);
        check("ds_idle", 256'({sel_active, selected_figure}), 256'd0);

        // Non-mask destination while SELECTED
        click(52);
        wait_cycles(2);
        push_ev(2'd1, 4'd0);
        click(20);
        wait_cycles(1);
        check("ill_still_sel", 256'({sel_active, selected_figure}), 256'h11);
        click(52);
        wait_cycles(1);
        check("ill_drain", 256'(sb.size()), 256'd0);
        check("ill_board", board, exp_board);

        // Pawn push e2-e4 with the mask present only in the sampling cycle
        possible_moves = '0;
        click(52);
        check("push_sel_fig", 256'(selected_figure), 256'd1);
        check("push_position", 256'(position), 256'd52);
        @(posedge clk);
        #1 possible_moves = mbit(36);
        @(posedge clk);
        #1 possible_moves = '0;
        check("push_selected", 256'(sel_active), 256'd1);
        push_ev(2'd2, 4'd0);
        click(36);
        wait_cycles(1);
        exp_board[4][4] = 4'd1;
        exp_board[6][4] = 4'd0;
        check("push_board", board, exp_board);
        check("push_turn", 256'(turn), 256'd1);
        check("push_sel_clear", 256'(selected_figure), 256'd0);
        wait_cycles(1);
        check("push_drain", 256'(sb.size()), 256'd0);

        // Walk a white pawn to a7, capture-promote on a8, then take the king
        do_move(8, 16);
        do_move(36, 8);
        do_move(9, 17);
        do_move(8, 0);
        check("promo_piece", 256'(board[0][0]), 256'd5);
        check("promo_captured", 256'(captured), 256'd10);
        check("promo_go", 256'(game_over), 256'd0);
        do_move(17, 25);
        do_move(0, 4);
        check("king_captured", 256'(captured), 256'd12);
        check("king_go", 256'(game_over), 256'd1);

        // Frozen after game over
        possible_moves = '1;
        click(11);
        click(40);
        wait_cycles(4);
        check("go_idle", 256'({sel_active, selected_figure}), 256'd0);
        check("go_board", board, exp_board);
        check("go_sticky", 256'(game_over), 256'd1);
        check("final_drain", 256'(sb.size()), 256'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
